alu_bist: RTL

ALU_BIST -- requirements
Module: alu_bist

---
 rtl/alu_bist_if.sv | 11 +
 rtl/alu_bist.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_bist_if.sv
// ALU stimulus/response bus between the BIST controller and the ALU under test.
interface alu_bist_if;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic       alu_carry;
    logic [7:0] alu_out;

    modport master (output alu_ctrl, alu_x, alu_y, input alu_carry, alu_out);
    modport slave  (input alu_ctrl, alu_x, alu_y, output alu_carry, alu_out);
endinterface

// File: rtl/alu_bist.sv
// LFSR-driven BIST for an 8-bit ALU with a pipelined golden-model compare.
// Optional macro ALU_BIST_STOP_ON_FAIL_EN: halt the run on the first mismatch.
module alu_bist #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    alu_bist_if.master  alu,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_cnt
);
    localparam logic [15:0] SEED_EFF = (SEED == '0) ? 16'hACE1 : SEED;
    localparam logic [15:0] LAST     = 16'(NUM_VECTORS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state;
    logic [15:0] index;
    logic [15:0] lfsr;
    logic        chk_q;
    logic        mis_q;
    logic [8:0]  golden;
    logic        mis_now;
    logic        halt;
    logic        lfsr_fb;
    logic [15:0] fail_nx;

    function automatic logic [8:0] golden_f(input logic [3:0] op,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
        logic [8:0] r;
        case (op)
            4'h0:    r = {x[7], x} + {y[7], y};
            4'h1:    r = {x[7], x} - {y[7], y};
            4'h2:    r = {1'b0, x & y};
            4'h3:    r = {1'b0, x | y};
            4'h4:    r = {1'b0, ~x};
            4'h5:    r = {1'b0, x ^ y};
            4'h6:    r = {1'b0, ~(x | y)};
            4'h7:    r = {1'b0, y << x[2:0]};
            4'h8:    r = {1'b0, y >> x[2:0]};
            4'h9:    r = {1'b0, x[7], x[7:1]};
            4'hA:    r = {1'b0, x[6:0], x[7]};
            4'hB:    r = {1'b0, x[0], x[7:1]};
            4'hC:    r = {8'h00, x == y};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Response of the vector held on the bus is checked one cycle after issue;
    // the mismatch is registered and counted on the following edge.
    always_comb begin
        golden  = golden_f(alu.alu_ctrl, alu.alu_x, alu.alu_y);
        mis_now = chk_q && ({alu.alu_carry, alu.alu_out} != golden);
        fail_nx = (mis_q && (fail_cnt != '1)) ? fail_cnt + 16'd1 : fail_cnt;
        lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        halt    = mis_now;
`else
        halt    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            alu.alu_ctrl <= '0;
            alu.alu_x    <= '0;
            alu.alu_y    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_cnt     <= '0;
            index        <= '0;
            lfsr         <= SEED_EFF;
            chk_q        <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            chk_q    <= 1'b0;
            mis_q    <= mis_now;
            fail_cnt <= fail_nx;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        fail_cnt <= '0;
                        mis_q    <= 1'b0;
                        index    <= '0;
                        lfsr     <= SEED_EFF;
                    end
                end
                RUN: begin
                    if ((index == LAST) || halt) begin
                        state <= DRAIN;
                    end else begin
                        alu.alu_ctrl <= index[3:0];
                        alu.alu_x    <= lfsr[15:8];
                        alu.alu_y    <= lfsr[7:0];
                        lfsr         <= {lfsr_fb, lfsr[15:1]};
                        index        <= index + 16'd1;
                        chk_q        <= 1'b1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (fail_nx == '0);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
